// File: rtl/door_pkg.sv
// door_pkg: shared state encoding, mode codes and sensor helper for the door controller.
// Revision: 1.0
`default_nettype none

package door_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } door_state_t;

  localparam logic [1:0] MODE_AUTO = 2'b00;
  localparam logic [1:0] MODE_HOLD = 2'b01;
  localparam logic [1:0] MODE_LOCK = 2'b10;

  // Motion only counts as a request when the door is not locked.
  function automatic logic motion_active(input logic motion, input logic [1:0] mode);
    return motion && (mode != MODE_LOCK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/door_controller_param_if.sv
// door_controller_param_if: sensor inputs and motor/status outputs of the door controller.
// Revision: 1.0
`default_nettype none

interface door_controller_param_if #(
  parameter int POS_W = 4
) ();

  logic             motion_sensor;
  logic             obstacle_sensor;
  logic [1:0]       mode;
  logic             fault_clr;
  logic             door_open;
  logic             door_close;
  logic             motor;
  logic             motor_dir;
  logic             fault;
  logic [POS_W-1:0] position;

  modport master (
    output motion_sensor, obstacle_sensor, mode, fault_clr,
    input  door_open, door_close, motor, motor_dir, fault, position
  );

  modport slave (
    input  motion_sensor, obstacle_sensor, mode, fault_clr,
    output door_open, door_close, motor, motor_dir, fault, position
  );

endinterface

`default_nettype wire

// File: rtl/door_travel_counter.sv
// door_travel_counter: saturating up/down door position counter with end-stop flags.
// Revision: 1.0
`default_nettype none

module door_travel_counter #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int POS_W         = $clog2(TRAVEL_CYCLES + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             en,
  input  wire logic             dir,
  output logic [POS_W-1:0]      position,
  output logic                  at_open,
  output logic                  at_closed
);

  localparam logic [POS_W-1:0] POS_FULL = POS_W'(TRAVEL_CYCLES);

  logic [POS_W-1:0] pos_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q <= '0;
    end else if (en) begin
      if (dir) begin
        if (pos_q != POS_FULL) pos_q <= pos_q + POS_W'(1);
      end else begin
        if (pos_q != '0) pos_q <= pos_q - POS_W'(1);
      end
    end
  end

  assign position  = pos_q;
  assign at_open   = (pos_q == POS_FULL);
  assign at_closed = (pos_q == '0);

endmodule

`default_nettype wire

// File: rtl/door_controller_param.sv
// door_controller_param: door motor sequencer with hold timer, operating modes and retry-limited fault lock-out.
// Revision: 1.0
`default_nettype none

module door_controller_param
  import door_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int HOLD_CYCLES   = 10,
  parameter int MAX_RETRY     = 3,
  parameter int POS_W         = $clog2(TRAVEL_CYCLES + 1)
) (
  input wire logic clk,
  input wire logic rst,
  door_controller_param_if.slave bus
);

  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [POS_W-1:0]   POS_NEAR_OPEN = POS_W'(TRAVEL_CYCLES - 1);
  localparam logic [POS_W-1:0]   POS_ONE       = POS_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_FULL     = HOLD_W'(HOLD_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LAST    = RETRY_W'(MAX_RETRY - 1);

  door_state_t        state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic               cnt_en, cnt_dir;
  logic [POS_W-1:0]   position;
  logic               at_open, at_closed;
  logic               obstacle, motion;

  assign obstacle = bus.obstacle_sensor;
  assign motion   = motion_active(bus.motion_sensor, bus.mode);

  door_travel_counter #(
    .TRAVEL_CYCLES (TRAVEL_CYCLES),
    .POS_W         (POS_W)
  ) u_travel (
    .clk       (clk),
    .rst       (rst),
    .en        (cnt_en),
    .dir       (cnt_dir),
    .position  (position),
    .at_open   (at_open),
    .at_closed (at_closed)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= CLOSED;
      hold_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    retry_nxt = retry_cnt;
    cnt_en    = 1'b0;
    cnt_dir   = 1'b0;
    case (state)
      CLOSED: begin
        retry_nxt = '0;
        if (bus.mode == MODE_HOLD || motion) state_nxt = OPENING;
      end
      OPENING: begin
        cnt_en  = 1'b1;
        cnt_dir = 1'b1;
        if (at_open || position == POS_NEAR_OPEN) begin
          state_nxt = OPEN;
          hold_nxt  = HOLD_FULL;
        end
      end
      OPEN: begin
        if (obstacle || motion) begin
          hold_nxt = HOLD_FULL;
        end else if (bus.mode != MODE_HOLD) begin
          if (hold_cnt != '0) hold_nxt = hold_cnt - HOLD_W'(1);
          if (hold_cnt <= HOLD_W'(1)) state_nxt = CLOSING;
        end
      end
      CLOSING: begin
        // A reversal wins over the final close step, so the counter is left idle.
        if (obstacle) begin
          if (retry_cnt == RETRY_LAST) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = OPENING;
            retry_nxt = retry_cnt + RETRY_W'(1);
          end
        end else if (motion) begin
          state_nxt = OPENING;
        end else begin
          cnt_en = 1'b1;
          if (position == POS_ONE || at_closed) begin
            state_nxt = CLOSED;
            retry_nxt = '0;
          end
        end
      end
      FAULT: begin
        if (bus.fault_clr && !obstacle) begin
          state_nxt = OPENING;
          retry_nxt = '0;
        end
      end
      default: state_nxt = CLOSED;
    endcase
  end

  assign bus.door_open  = (state == OPEN);
  assign bus.door_close = (state == CLOSED);
  assign bus.motor      = (state == OPENING) || (state == CLOSING);
  assign bus.motor_dir  = (state == OPENING);
  assign bus.fault      = (state == FAULT);
  assign bus.position   = position;

endmodule

`default_nettype wire

// File: tb/tb_door_controller_param.sv
// tb_door_controller_param: directed scenarios plus random stimulus against a behavioural door model.
// Revision: 1.0
`default_nettype none

module tb_door_controller_param;

  localparam int T = 8;
  localparam int H = 10;
  localparam int R = 3;
  localparam int PW = $clog2(T + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  door_controller_param_if #(.POS_W(PW)) bus ();

  door_controller_param #(
    .TRAVEL_CYCLES (T),
    .HOLD_CYCLES   (H),
    .MAX_RETRY     (R),
    .POS_W         (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Door model: position, travel direction (-1/0/+1), dwell time left, reversal count, lock-out flag.
  int m_pos = 0;
  int m_dir = 0;
  int m_hold = 0;
  int m_retry = 0;
  bit m_faulted = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit obs, mot;
    obs = bus.obstacle_sensor;
    mot = bus.motion_sensor && (bus.mode != 2'd2);
    if (!rst) begin
      m_pos = 0; m_dir = 0; m_hold = 0; m_retry = 0; m_faulted = 1'b0;
    end else if (m_faulted) begin
      if (bus.fault_clr && !obs) begin
        m_faulted = 1'b0; m_dir = 1; m_retry = 0;
      end
    end else if (m_dir == 1) begin
      m_pos = (m_pos + 1 > T) ? T : m_pos + 1;
      if (m_pos == T) begin
        m_dir = 0; m_hold = H;
      end
    end else if (m_dir == -1) begin
      if (obs) begin
        if (m_retry == R - 1) begin
          m_faulted = 1'b1; m_dir = 0;
        end else begin
          m_retry++; m_dir = 1;
        end
      end else if (mot) begin
        m_dir = 1;
      end else begin
        m_pos--;
        if (m_pos == 0) begin
          m_dir = 0; m_retry = 0;
        end
      end
    end else if (m_pos == 0) begin
      m_retry = 0;
      if (bus.mode == 2'd1 || mot) m_dir = 1;
    end else begin
      if (obs || mot) m_hold = H;
      else if (bus.mode != 2'd1) begin
        m_hold--;
        if (m_hold == 0) m_dir = -1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("door_open",  int'(bus.door_open),  int'(!m_faulted && m_dir == 0 && m_pos == T));
    check("door_close", int'(bus.door_close), int'(!m_faulted && m_dir == 0 && m_pos == 0));
    check("motor",      int'(bus.motor),      int'(!m_faulted && m_dir != 0));
    check("motor_dir",  int'(bus.motor_dir),  int'(!m_faulted && m_dir == 1));
    check("fault",      int'(bus.fault),      int'(m_faulted));
    check("position",   int'(bus.position),   m_pos);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_motion();
    bus.motion_sensor = 1'b1;
    cycle();
    bus.motion_sensor = 1'b0;
  endtask

  // Pulse the obstacle once the model is closing at position p; an expired budget is a failure.
  task automatic obstacle_at_closing(input string tag, input int p);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_dir == -1 && !m_faulted && m_pos == p) begin
        found = 1'b1;
        bus.obstacle_sensor = 1'b1;
        cycle();
        bus.obstacle_sensor = 1'b0;
      end else begin
        cycle();
      end
    end
    check(tag, int'(found), 1);
  endtask

  initial begin
    bus.motion_sensor   = 1'b0;
    bus.obstacle_sensor = 1'b0;
    bus.mode            = 2'b00;
    bus.fault_clr       = 1'b0;
    rst = 1'b0;
    run(2);
    rst = 1'b1;

    // Basic open/hold/close cycle
    pulse_motion();
    run(30);

    // Single obstacle reversal at position 5
    pulse_motion();
    obstacle_at_closing("reach_rev", 5);
    run(40);

    // Three reversals lead to lock-out; clear is refused while obstructed
    pulse_motion();
    obstacle_at_closing("reach_obs1", 6);
    obstacle_at_closing("reach_obs2", 6);
    obstacle_at_closing("reach_obs3", 6);
    check("fault_entered", int'(bus.fault), 1);
    bus.fault_clr = 1'b1;
    bus.obstacle_sensor = 1'b1;
    run(3);
    bus.obstacle_sensor = 1'b0;
    cycle();
    bus.fault_clr = 1'b0;
    run(40);

    // Modes: locked ignores motion, hold-open dwells, auto closes afterwards
    bus.mode = 2'b10;
    bus.motion_sensor = 1'b1;
    run(20);
    bus.motion_sensor = 1'b0;
    bus.mode = 2'b01;
    run(60);
    bus.mode = 2'b00;
    run(30);

    // Hold reload by periodic motion
    pulse_motion();
    run(10);
    for (int k = 0; k < 8; k++) begin
      pulse_motion();
      run(4);
    end
    run(30);

    // Reset mid-travel at position 4
    pulse_motion();
    for (int i = 0; i < 20 && !(m_dir == 1 && m_pos == 4); i++) cycle();
    check("reach_pos4", int'(m_dir == 1 && m_pos == 4), 1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    run(3);

    // Reset while locked out
    pulse_motion();
    obstacle_at_closing("reach_f1", 7);
    obstacle_at_closing("reach_f2", 7);
    obstacle_at_closing("reach_f3", 7);
    run(3);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    run(3);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bus.motion_sensor   = ($urandom_range(0, 7) == 0);
      bus.obstacle_sensor = ($urandom_range(0, 15) == 0);
      bus.fault_clr       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) bus.mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/door_controller_param.md
Name: door_controller_param

Overview:
Parametrised successor to the team's single-speed automatic door controller. Drives a door motor through travel with a position counter, a configurable hold-open time and safety reversal on obstacle or motion. Adds operating modes (auto, hold-open, locked) and a retry-limited fault lock-out. Sits between the sensor conditioning logic and the motor driver.

Parameters:
TRAVEL_CYCLES, 8, clock cycles of motor drive for full open or full close travel (>=2)
HOLD_CYCLES, 10, cycles the door dwells fully open with no motion before closing (>=1)
MAX_RETRY, 3, obstacle reversals in one open/close cycle; the MAX_RETRY-th obstacle enters FAULT (>=1)
POS_W, $clog2(TRAVEL_CYCLES+1), width of the position counter (derived)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; one clock, synchronous, active-low
motion_sensor  input  1  person detected, level, sampled each edge
obstacle_sensor  input  1  obstruction in doorway, level
mode  input  2  00 auto, 01 hold-open, 10 locked, 11 treated as auto
fault_clr  input  1  operator clear of FAULT
door_open  output  1  door fully open (state OPEN)
door_close  output  1  door fully closed (state CLOSED)
motor  output  1  motor energised (OPENING or CLOSING)
motor_dir  output  1  1 = opening, 0 = closing; 0 when motor=0
fault  output  1  state FAULT
position  output  POS_W  0 = closed, TRAVEL_CYCLES = fully open

Behaviour:
- Reset: rst=0 at a clk edge -> state CLOSED, position=0, hold and retry counters=0. Outputs: door_close=1; all others 0. Reset overrides everything, including mid-travel and FAULT.
- Outputs are Moore: registered state decode only, no combinational input-to-output path.
- Sensor inputs take effect on the edge that samples them. Outputs change one cycle after that edge.

CLOSED:
- Go to OPENING on either condition:
  - mode=01.
  - motion_sensor=1 and mode!=10.
- Otherwise stay.

OPENING:
- position+1 each cycle.
- When position reaches TRAVEL_CYCLES, go to OPEN and load the hold counter with HOLD_CYCLES.
- Sensors are ignored.

OPEN:
- The hold counter decrements each cycle in modes 00, 10 and 11. It is frozen in mode 01.
- motion_sensor=1 in mode!=10 reloads HOLD_CYCLES.
- obstacle_sensor=1 reloads HOLD_CYCLES in any mode.
- When the counter reaches 0, go to CLOSING.

CLOSING:
- position-1 each cycle.
- Reversal on obstacle_sensor=1, or on motion_sensor=1 in mode!=10:
  - If retry_cnt==MAX_RETRY-1 and the trigger is an obstacle, go to FAULT.
  - Otherwise go to OPENING from the current position, so reversal travel = TRAVEL_CYCLES-position cycles.
  - retry_cnt increments only on obstacle reversals.
- Simultaneous obstacle and motion: treated as an obstacle.
- A reversal checked on the same edge that position would hit 0 takes priority; position holds its value.
- position reaching 0 -> CLOSED, retry_cnt cleared.
- mode changing to 01 during CLOSING does not reverse. The door reopens from CLOSED on the next cycle.

FAULT:
- motor=0, position frozen.
- fault_clr=1 and obstacle_sensor=0 -> OPENING, retry_cnt cleared.
- fault_clr with obstacle_sensor=1 is ignored.
- mode is ignored.

Width rules:
- position saturates within 0..TRAVEL_CYCLES and never wraps.
- retry_cnt width is $clog2(MAX_RETRY+1).
- The hold counter is $clog2(HOLD_CYCLES+1) wide.

Decomposition:
- Package door_pkg:
  - State enum: CLOSED, OPENING, OPEN, CLOSING, FAULT (3-bit encoding).
  - Mode localparams: MODE_AUTO=2'b00, MODE_HOLD=2'b01, MODE_LOCK=2'b10.
- One natural sub-module, door_travel_counter: up/down saturating position counter with en, dir, at_open and at_closed flags.
- The FSM, hold timer and retry counter stay in the top module.

Test Plan (default parameters):
1. Basic cycle: rst=0 for 2 cycles, release; motion_sensor=1 for 1 cycle.
   - motor=1, motor_dir=1 for 8 cycles.
   - door_open=1 for 10 cycles.
   - motor=1, motor_dir=0 for 8 cycles.
   - door_close=1, position 0->8->0.
2. Obstacle reversal: obstacle_sensor=1 for 1 cycle when position=5 during CLOSING.
   - Next state OPENING, reopens in 3 cycles.
   - Full 10-cycle hold, then closes normally.
   - retry_cnt=1, cleared at CLOSED.
3. Fault: three obstacles in successive CLOSING phases.
   - Third obstacle -> fault=1, motor=0, position frozen.
   - fault_clr=1 with obstacle_sensor=1: remains in FAULT.
   - fault_clr=1 with obstacle_sensor=0: OPENING, fault=0.
4. Modes:
   - mode=10 with motion_sensor held high from CLOSED: door stays closed for 20 cycles.
   - mode=01 from CLOSED: opens without motion and stays open 50 cycles.
   - Switch to 00: closes after 10 cycles.
5. Hold reload: motion_sensor pulses every 5 cycles in OPEN.
   - Door never closes.
   - After the last pulse, CLOSING starts exactly 10 cycles later.
6. Reset mid-travel: rst=0 at position=4 in OPENING.
   - Next cycle state CLOSED, position=0, door_close=1, motor=0.
   - Also check reset while in FAULT clears fault.
